// File: rtl/cp_pkg.sv
// cp_pkg: core-wide default widths and reset constants shared by fetch, core and dmem
package cp_pkg;
   localparam int CP_ADDR_W = 12;
   localparam int CP_DATA_W = 32;
   localparam logic [CP_ADDR_W-1:0] CP_RESET_PC = '0;
endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo: DEPTH-entry queue of fetched words with flush taking priority over push/pop
module prefetch_fifo
   import cp_pkg::*;
#(
   parameter int WIDTH = CP_DATA_W + CP_ADDR_W,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [CNT_W-1:0] count
);
   localparam int PTR_W = $clog2(DEPTH);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_pop;
   logic             w_push;
   assign w_pop  = pop && (r_count != '0);
   assign w_push = push;
   assign count  = r_count;
   assign rdata  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
   // pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of 2
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end
   // storage array; contents are only observed through a valid head so no reset is needed
   always_ff @(posedge clock) begin
      if (w_push && !flush) r_mem[r_wr_ptr] <= wdata;
   end
   // the issue throttle upstream must make a push into a full queue impossible
   always_ff @(posedge clock) begin
      if (!reset && w_push && !flush) assert (r_count != CNT_W'(DEPTH));
   end
endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: PC owner driving a synchronous imem and feeding decode from a prefetch queue
module fetch_prefetch_unit
   import cp_pkg::*;
#(
   parameter int ADDR_W = CP_ADDR_W,
   parameter int DATA_W = CP_DATA_W,
   parameter int DEPTH  = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(CP_RESET_PC)
) (
   input  logic                     clock,
   input  logic                     reset,
   output logic [ADDR_W-1:0]        imem_address,
   output logic                     imem_clken,
   input  logic [DATA_W-1:0]        imem_q,
   input  logic                     redirect_valid,
   input  logic [ADDR_W-1:0]        redirect_pc,
   output logic                     insn_valid,
   input  logic                     insn_ready,
   output logic [DATA_W-1:0]        insn,
   output logic [ADDR_W-1:0]        insn_pc,
   output logic [$clog2(DEPTH):0]   fill_count
);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(DEPTH);
   logic [ADDR_W-1:0]        r_pc;
   logic [ADDR_W-1:0]        r_resp_pc;
   logic                     r_resp_pending;
   logic [CNT_W-1:0]         w_count;
   logic [CNT_W:0]           w_occupancy;
   logic                     w_issue;
   logic [DATA_W+ADDR_W-1:0] w_head;
   assign w_occupancy  = {1'b0, w_count} + (CNT_W + 1)'(r_resp_pending);
   assign w_issue      = !reset && !redirect_valid && (w_occupancy < DEPTH_V);
   assign imem_clken   = w_issue;
   assign imem_address = r_pc;
   assign insn_valid   = (w_count != '0);
   assign insn         = w_head[DATA_W+ADDR_W-1:ADDR_W];
   assign insn_pc      = w_head[ADDR_W-1:0];
   assign fill_count   = w_count;
   // PC advance, redirect load and tracking of the single outstanding imem read
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_pc           <= RESET_PC;
         r_resp_pc      <= '0;
         r_resp_pending <= 1'b0;
      end else begin
         r_resp_pending <= w_issue;
         if (w_issue) r_resp_pc <= r_pc;
         r_pc <= redirect_valid ? redirect_pc : (w_issue ? r_pc + 1'b1 : r_pc);
      end
   end
   prefetch_fifo #(
      .WIDTH (DATA_W + ADDR_W),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (r_resp_pending && !redirect_valid),
      .pop   (insn_valid && insn_ready),
      .flush (redirect_valid),
      .wdata ({imem_q, r_resp_pc}),
      .rdata (w_head),
      .count (w_count)
   );
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: directed checks of fetch streaming, backpressure, redirect, wrap and async reset
module tb_fetch_prefetch_unit;
   logic        clock;
   logic        reset;
   logic [11:0] imem_address;
   logic        imem_clken;
   logic [31:0] imem_q;
   logic        redirect_valid;
   logic [11:0] redirect_pc;
   logic        insn_valid;
   logic        insn_ready;
   logic [31:0] insn;
   logic [11:0] insn_pc;
   logic [2:0]  fill_count;
   int          n_cmp = 0;
   int          n_err = 0;

   fetch_prefetch_unit dut (
      .clock          (clock),
      .reset          (reset),
      .imem_address   (imem_address),
      .imem_clken     (imem_clken),
      .imem_q         (imem_q),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .insn_valid     (insn_valid),
      .insn_ready     (insn_ready),
      .insn           (insn),
      .insn_pc        (insn_pc),
      .fill_count     (fill_count)
   );

   function automatic logic [31:0] word(input logic [11:0] a);
      return {8'hC3, a, ~a};
   endfunction

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // synchronous-read imem: data appears the cycle after a clock-enabled address
   always @(posedge clock) if (imem_clken) imem_q <= word(imem_address);

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      imem_q = '0;
      reset = 1'b1;
      insn_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      tick;
      chk("rst_valid", insn_valid, 0);
      chk("rst_clken", imem_clken, 0);
      chk("rst_fill", fill_count, 0);
      chk("rst_insn", insn, 0);
      chk("rst_insn_pc", insn_pc, 0);
      chk("rst_addr", imem_address, 0);
      reset = 1'b0;
      #1;
      chk("first_clken", imem_clken, 1);
      chk("first_addr", imem_address, 0);
      tick;
      chk("e1_valid", insn_valid, 0);
      chk("e1_addr", imem_address, 1);
      for (int k = 2; k <= 7; k++) begin
         tick;
         chk("stream_valid", insn_valid, 1);
         chk("stream_pc", insn_pc, 64'(k - 2));
         chk("stream_insn", insn, {32'h0, word(12'(k - 2))});
         chk("stream_addr", imem_address, 64'(k));
      end
      #2 reset = 1'b1;
      #1;
      chk("async_valid", insn_valid, 0);
      chk("async_clken", imem_clken, 0);
      chk("async_fill", fill_count, 0);
      insn_ready = 1'b0;
      tick;
      reset = 1'b0;
      tick;
      chk("bp_e1_valid", insn_valid, 0);
      for (int k = 2; k <= 10; k++) begin
         tick;
         chk("bp_hold_pc", insn_pc, 0);
         chk("bp_hold_insn", insn, {32'h0, word(12'h000)});
      end
      chk("bp_fill", fill_count, 4);
      chk("bp_clken", imem_clken, 0);
      chk("bp_addr", imem_address, 4);
      insn_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick;
         chk("drain_valid", insn_valid, 1);
         chk("drain_pc", insn_pc, 64'(k));
      end
      #2 reset = 1'b1;
      #1;
      insn_ready = 1'b0;
      tick;
      reset = 1'b0;
      for (int k = 1; k <= 4; k++) tick;
      chk("pre_redir_fill", fill_count, 3);
      redirect_valid = 1'b1;
      redirect_pc = 12'h0A0;
      #1;
      chk("redir_clken", imem_clken, 0);
      tick;
      redirect_valid = 1'b0;
      insn_ready = 1'b1;
      #1;
      chk("redir_fill", fill_count, 0);
      chk("redir_valid", insn_valid, 0);
      chk("redir_addr", imem_address, 12'h0A0);
      chk("redir_issue", imem_clken, 1);
      tick;
      chk("redir_n1_valid", insn_valid, 0);
      tick;
      chk("redir_n2_valid", insn_valid, 1);
      chk("redir_n2_pc", insn_pc, 12'h0A0);
      chk("redir_n2_insn", insn, {32'h0, word(12'h0A0)});
      tick;
      chk("redir_n3_pc", insn_pc, 12'h0A1);
      redirect_valid = 1'b1;
      redirect_pc = 12'hFFE;
      tick;
      redirect_valid = 1'b0;
      chk("wrap_flush_valid", insn_valid, 0);
      tick;
      tick;
      chk("wrap_pc0", insn_pc, 12'hFFE);
      tick;
      chk("wrap_pc1", insn_pc, 12'hFFF);
      tick;
      chk("wrap_pc2", insn_pc, 12'h000);
      chk("wrap_insn2", insn, {32'h0, word(12'h000)});
      tick;
      chk("wrap_pc3", insn_pc, 12'h001);
      chk("pop_redir_pre_valid", insn_valid, 1);
      redirect_valid = 1'b1;
      redirect_pc = 12'h123;
      tick;
      redirect_valid = 1'b0;
      chk("pop_redir_valid", insn_valid, 0);
      chk("pop_redir_fill", fill_count, 0);
      tick;
      chk("pop_redir_n1_valid", insn_valid, 0);
      tick;
      chk("pop_redir_pc", insn_pc, 12'h123);
      tick;
      chk("pop_redir_next", insn_pc, 12'h124);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
